// File: rtl/bmc_acs_unit_if.sv
// Symbol-in / survivor-out bundle of the Viterbi branch-metric + ACS stage.
interface bmc_acs_unit_if #(
    parameter int PM_W = 6
);
    logic            d_in_valid;
    logic [1:0]      d_in;
    logic            frame_start;
    logic [7:0]      selection;
    logic            sel_valid;
    logic [2:0]      best_state;
    logic [PM_W-1:0] pm_min;
    logic            norm_pulse;

    modport master (
        output d_in_valid, d_in, frame_start,
        input  selection, sel_valid, best_state, pm_min, norm_pulse
    );

    modport slave (
        input  d_in_valid, d_in, frame_start,
        output selection, sel_valid, best_state, pm_min, norm_pulse
    );
endinterface

// File: rtl/bmc_acs_unit.sv
// Hard-decision branch metric + add-compare-select for the K=4, rate-1/2 code.
// Eight path metrics, MSB-clear normalisation, one survivor word per symbol.
module bmc_acs_unit #(
    parameter int          PM_W    = 6,
    parameter logic [3:0]  G0      = 4'b1101,
    parameter logic [3:0]  G1      = 4'b1111,
    parameter int          PM_INIT = 8
) (
    input  logic          clk,
    input  logic          RSTn,
    bmc_acs_unit_if.slave bus
);
    localparam logic [PM_W-1:0] INIT = PM_W'(PM_INIT);

    logic [PM_W-1:0] pm_q   [8];
    logic [PM_W-1:0] src    [8];
    logic [PM_W-1:0] pm_nrm [8];
    logic [7:0]      sel_d;
    logic [7:0]      msb;
    logic            all_msb;
    logic [2:0]      best_idx;
    logic [PM_W-1:0] best_val;

    function automatic logic [PM_W:0] bm(
        input logic [3:0] r,
        input logic [1:0] d
    );
        logic [1:0] x;
        x = {^(G0 & r), ^(G1 & r)} ^ d;
        return (PM_W+1)'(x[1]) + (PM_W+1)'(x[0]);
    endfunction

    assign all_msb = &msb;

    for (genvar n = 0; n < 8; n++) begin : g_acs
        localparam logic [2:0] NS = 3'(n);
        localparam logic [2:0] P0 = {NS[1:0], 1'b0};
        localparam logic [2:0] P1 = {NS[1:0], 1'b1};
        logic [PM_W:0]   c0;
        logic [PM_W:0]   c1;
        logic [PM_W-1:0] pm_new;

        // frame_start makes the reset metrics the sources of this symbol
        assign src[n] = bus.frame_start ?
                        ((n == 0) ? '0 : INIT) : pm_q[n];

        assign c0 = {1'b0, src[P0]} + bm({NS[2], P0}, bus.d_in);
        assign c1 = {1'b0, src[P1]} + bm({NS[2], P1}, bus.d_in);

        assign sel_d[n] = (c1 < c0);
        assign pm_new   = sel_d[n] ? c1[PM_W-1:0] : c0[PM_W-1:0];
        assign msb[n]   = pm_new[PM_W-1];

        assign pm_nrm[n] = all_msb ?
                           {1'b0, pm_new[PM_W-2:0]} : pm_new;
    end

    always_comb begin
        best_idx = '0;
        best_val = pm_nrm[0];
        for (int i = 1; i < 8; i++) begin
            if (pm_nrm[i] < best_val) begin
                best_val = pm_nrm[i];
                best_idx = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < 8; i++)
                pm_q[i] <= (i == 0) ? '0 : INIT;
            bus.selection  <= '0;
            bus.sel_valid  <= 1'b0;
            bus.best_state <= '0;
            bus.pm_min     <= '0;
            bus.norm_pulse <= 1'b0;
        end else begin
            bus.sel_valid  <= bus.d_in_valid;
            bus.norm_pulse <= bus.d_in_valid & all_msb;
            if (bus.d_in_valid) begin
                for (int i = 0; i < 8; i++)
                    pm_q[i] <= pm_nrm[i];
                bus.selection  <= sel_d;
                bus.best_state <= best_idx;
                bus.pm_min     <= best_val;
            end else if (bus.frame_start) begin
                for (int i = 0; i < 8; i++)
                    pm_q[i] <= src[i];
            end
        end
    end
endmodule

// File: tb/tb_bmc_acs_unit.sv
// Randomised bench for bmc_acs_unit against a forward-trellis reference.
module tb_bmc_acs_unit;
    localparam int PM_W = 6;
    localparam int G0 = 4'b1101;
    localparam int G1 = 4'b1111;
    localparam int PM_INIT = 8;

    logic clk;
    logic RSTn;

    bmc_acs_unit_if #(.PM_W(PM_W)) bus ();

    bmc_acs_unit #(.PM_W(PM_W)) dut (
        .clk  (clk),
        .RSTn (RSTn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_norm = 0;

    int pm [8];
    int exp_sel, exp_best, exp_min, exp_norm;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int code(input int u, input int s);
        int r, c0, c1;
        r  = (u << 3) | s;
        c0 = $countones(G0 & r) & 1;
        c1 = $countones(G1 & r) & 1;
        return (c0 << 1) | c1;
    endfunction

    task automatic model_init();
        pm[0] = 0;
        for (int i = 1; i < 8; i++) pm[i] = PM_INIT;
    endtask

    task automatic model_reset();
        model_init();
        exp_sel = 0; exp_best = 0; exp_min = 0; exp_norm = 0;
    endtask

    // Forward trellis: every (state, input) pair extends one path
    task automatic model_step(input int d, input bit fs);
        int nw [8];
        int ns, cand, all_hi;
        if (fs) model_init();
        for (int i = 0; i < 8; i++) nw[i] = 1 << 30;
        exp_sel = 0;
        for (int s = 0; s < 8; s++) begin
            for (int u = 0; u < 2; u++) begin
                ns   = (u << 2) | (s >> 1);
                cand = pm[s] + $countones(code(u, s) ^ d);
                if (cand < nw[ns]) begin
                    nw[ns] = cand;
                    if (s & 1) exp_sel |= (1 << ns);
                    else exp_sel &= ~(1 << ns);
                end
            end
        end
        all_hi = 1;
        for (int i = 0; i < 8; i++)
            if (nw[i] < (1 << (PM_W-1))) all_hi = 0;
        exp_norm = all_hi;
        for (int i = 0; i < 8; i++)
            pm[i] = all_hi ? nw[i] - (1 << (PM_W-1)) : nw[i];
        exp_best = 0;
        exp_min  = pm[0];
        for (int i = 1; i < 8; i++)
            if (pm[i] < exp_min) begin
                exp_min = pm[i];
                exp_best = i;
            end
    endtask

    task automatic check_outs(input bit v);
        chk("sel_valid", bus.sel_valid, v);
        chk("selection", bus.selection, exp_sel);
        chk("best_state", bus.best_state, exp_best);
        chk("pm_min", bus.pm_min, exp_min);
        chk("norm_pulse", bus.norm_pulse, exp_norm);
    endtask

    task automatic step(input bit v, input logic [1:0] d, input bit fs);
        bus.d_in_valid  = v;
        bus.d_in        = d;
        bus.frame_start = fs;
        @(posedge clk);
        #1;
        if (v) model_step(int'(d), fs);
        else begin
            if (fs) model_init();
            exp_norm = 0;
        end
        if (bus.norm_pulse === 1'b1) n_norm++;
        check_outs(v);
        bus.d_in_valid  = 1'b0;
        bus.frame_start = 1'b0;
    endtask

    task automatic apply_reset();
        RSTn = 1'b0;
        @(posedge clk);
        #3;
        RSTn = 1'b1;
        model_reset();
    endtask

    initial begin
        int s, u, d;
        int us [7];
        RSTn = 1'b0;
        bus.d_in_valid  = 1'b0;
        bus.d_in        = 2'b00;
        bus.frame_start = 1'b0;
        model_reset();
        #12;
        check_outs(1'b0);
        RSTn = 1'b1;

        // single all-zero symbol
        step(1'b1, 2'b00, 1'b0);
        chk("t1_sel0", bus.selection[0], 1'b0);
        chk("t1_best", bus.best_state, 3'd0);
        chk("t1_min", bus.pm_min, 6'd0);
        step(1'b0, 2'b00, 1'b0);

        // all-zero stream stays on state 0 without normalising
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 2'b00, 1'b0);
            chk("t2_best", bus.best_state, 3'd0);
            chk("t2_min", bus.pm_min, 6'd0);
        end

        // encoded sequence with one flipped bit
        apply_reset();
        us = '{1, 0, 1, 1, 0, 0, 0};
        s = 0;
        for (int i = 0; i < 7; i++) begin
            u = us[i];
            d = code(u, s);
            if (i == 2) d ^= 2;
            s = (u << 2) | (s >> 1);
            step(1'b1, 2'(d), 1'b0);
        end
        chk("t3_best", bus.best_state, 3'd0);
        chk("t3_min", bus.pm_min, 6'd1);

        // random noise, 70% valid duty, occasional frame restarts
        apply_reset();
        n_norm = 0;
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 99) < 70, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 199) == 0);
        end
        chk("t4_norm_seen", n_norm != 0, 1'b1);

        // frame restart carried by a symbol
        step(1'b1, 2'b11, 1'b1);
        chk("t5_sel0", bus.selection[0], 1'b0);
        chk("t5_best", bus.best_state, 3'd4);
        chk("t5_min", bus.pm_min, 6'd0);

        // asynchronous reset mid-burst
        step(1'b1, 2'b01, 1'b0);
        step(1'b1, 2'b10, 1'b0);
        RSTn = 1'b0;
        #2;
        model_reset();
        check_outs(1'b0);
        #2;
        RSTn = 1'b1;
        step(1'b0, 2'b00, 1'b0);
        step(1'b1, 2'b00, 1'b0);
        chk("t6_sel0", bus.selection[0], 1'b0);
        chk("t6_best", bus.best_state, 3'd0);
        chk("t6_min", bus.pm_min, 6'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
